aes_lane_scheduler: RTL

- Parametrised successor to the single encrypt/decrypt AES block wrapper.
- Dispatches 128-bit blocks from the RX FIFO side to NUM_LANES external AES engine lanes in round-robin order.
- Latches encrypt/decrypt mode per block, so mode may change block-to-block.
- Collects results strictly in issue order and presents them to the TX FIFO side under backpressure.

---
 rtl/aes_lane_scheduler_pkg.sv | 6 +
 rtl/aes_lane_scheduler_if.sv | 7 +
 rtl/aes_lane_scheduler_slot.sv | 29 ++
 rtl/aes_lane_scheduler.sv | 82 ++++++++
 4 files changed

// File: rtl/aes_lane_scheduler_pkg.sv
// aes_sched_pkg: shared lane state type and size limits for the AES lane scheduler
package aes_sched_pkg;
  typedef enum logic [1:0] {LANE_IDLE, LANE_BUSY, LANE_DONE} lane_state_t;
  localparam int AES_BLOCK_W = 128;
  localparam int MAX_LANES = 8;
endpackage

// File: rtl/aes_lane_scheduler_if.sv
// aes_lane_scheduler_if: RX-side block input and TX-side result output handshakes
interface aes_lane_scheduler_if import aes_sched_pkg::*; #(parameter int DATA_W = AES_BLOCK_W);
  logic in_valid, in_ready, in_encrypt, out_valid, out_encrypt, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  modport master(output in_valid, in_data, in_encrypt, out_ready, input in_ready, out_valid, out_data, out_encrypt);
  modport slave(input in_valid, in_data, in_encrypt, out_ready, output in_ready, out_valid, out_data, out_encrypt);
endinterface

// File: rtl/aes_lane_scheduler_slot.sv
// aes_lane_slot: one engine lane's IDLE/BUSY/DONE state with latched mode and captured result
module aes_lane_slot import aes_sched_pkg::*; #(parameter int DATA_W = AES_BLOCK_W) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              accept,
  input  logic              encrypt,
  input  logic              done,
  input  logic              rel,
  input  logic [DATA_W-1:0] result_in,
  output lane_state_t       state,
  output logic              mode,
  output logic [DATA_W-1:0] result,
  output logic              spurious
);
  assign spurious = done && state != LANE_BUSY;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= LANE_IDLE;
      mode <= 1'b0;
      result <= '0;
    end else if (accept && state == LANE_IDLE) begin
      state <= LANE_BUSY;
      mode <= encrypt;
    end else if (done && state == LANE_BUSY) begin
      state <= LANE_DONE;
      result <= result_in;
    end else if (rel && state == LANE_DONE)
      state <= LANE_IDLE;
endmodule

// File: rtl/aes_lane_scheduler.sv
// aes_lane_scheduler: round-robin dispatch of blocks to AES lanes with in-order result collection
module aes_lane_scheduler import aes_sched_pkg::*; #(
  parameter int NUM_LANES = 2,
  parameter int DATA_W = AES_BLOCK_W,
  localparam int CNT_W = $clog2(NUM_LANES + 1)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  aes_lane_scheduler_if.slave           bus,
  output logic [NUM_LANES-1:0]          lane_start,
  output logic [NUM_LANES-1:0]          lane_encrypt,
  output logic [DATA_W-1:0]             lane_data,
  input  logic [NUM_LANES-1:0]          lane_done,
  input  logic [NUM_LANES*DATA_W-1:0]   lane_result,
  output logic [CNT_W-1:0]              blocks_in_flight,
  output logic                          err_spurious_done
);
  localparam int PTR_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_LANES - 1);
  if (NUM_LANES < 1 || NUM_LANES > MAX_LANES) begin : g_bad_num_lanes
    $error("NUM_LANES out of range");
  end
  logic [PTR_W-1:0] issue_ptr, collect_ptr;
  lane_state_t state [NUM_LANES];
  logic [DATA_W-1:0] result [NUM_LANES];
  logic [NUM_LANES-1:0] spurious;
  logic [DATA_W-1:0] out_data;
  logic in_ready, out_valid, out_encrypt, accept, xfer;
  always_comb begin
    in_ready = 1'b0;
    out_valid = 1'b0;
    out_encrypt = 1'b0;
    out_data = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (issue_ptr == PTR_W'(k)) in_ready = state[k] == LANE_IDLE;
      if (collect_ptr == PTR_W'(k)) begin
        out_valid = state[k] == LANE_DONE;
        out_encrypt = lane_encrypt[k];
        out_data = result[k];
      end
    end
  end
  assign accept = bus.in_valid && in_ready;
  assign xfer = out_valid && bus.out_ready;
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_encrypt = out_encrypt;
  assign bus.out_data = out_data;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    aes_lane_slot #(.DATA_W(DATA_W)) u_slot (
      .clk(clk),
      .n_rst(n_rst),
      .accept(accept && issue_ptr == PTR_W'(i)),
      .encrypt(bus.in_encrypt),
      .done(lane_done[i]),
      .rel(xfer && collect_ptr == PTR_W'(i)),
      .result_in(lane_result[i*DATA_W +: DATA_W]),
      .state(state[i]),
      .mode(lane_encrypt[i]),
      .result(result[i]),
      .spurious(spurious[i])
    );
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      issue_ptr <= '0;
      collect_ptr <= '0;
      lane_start <= '0;
      lane_data <= '0;
      blocks_in_flight <= '0;
      err_spurious_done <= 1'b0;
    end else begin
      lane_start <= accept ? NUM_LANES'(1) << issue_ptr : '0;
      if (accept) begin
        lane_data <= bus.in_data;
        issue_ptr <= issue_ptr == LAST ? '0 : issue_ptr + 1'b1;
      end
      if (xfer) collect_ptr <= collect_ptr == LAST ? '0 : collect_ptr + 1'b1;
      blocks_in_flight <= blocks_in_flight + CNT_W'(accept) - CNT_W'(xfer);
      err_spurious_done <= err_spurious_done | (|spurious);
    end
endmodule
